// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared types and constants for the USB transmit bit path
package usb_tx_pkg;
  typedef enum logic [1:0] {TX_IDLE, TX_SHIFT, TX_STUFF} tx_state_t;
  localparam int STUFF_LIMIT_DEF = 6;
  localparam int BYTE_W = 8;
endpackage

// File: rtl/piso_tx_serializer.sv
// piso_tx_serializer: MSB-first byte serializer with one-entry holding register and optional bit stuffing
module piso_tx_serializer
  import usb_tx_pkg::*;
#(
  parameter bit STUFF_EN    = 1'b1,
  parameter int STUFF_LIMIT = STUFF_LIMIT_DEF
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              shift_enable,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              data_last,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              serial_out,
  output logic              tx_active,
  output logic              byte_done,
  output logic              done,
  output logic              underrun
);
  localparam logic [2:0] LIM = STUFF_LIMIT[2:0];
  tx_state_t state, state_n;
  logic              hold_valid, hold_last, hold_take;
  logic [BYTE_W-1:0] hold_data, shifter, shifter_n;
  logic              cur_last, cur_last_n, done_pending, done_pending_n, stuff;
  logic [2:0]        bit_cnt, bit_cnt_n, ones_cnt, ones_cnt_n, ones_inc;
  assign data_ready = !hold_valid;
  assign tx_active  = state != TX_IDLE;
  assign serial_out = state == TX_SHIFT ? shifter[BYTE_W-1] : state != TX_STUFF;
  assign ones_inc   = shifter[BYTE_W-1] ? ones_cnt + 3'd1 : 3'd0;
  assign stuff      = STUFF_EN && ones_inc == LIM;
  always_comb begin
    state_n        = state;
    shifter_n      = shifter;
    cur_last_n     = cur_last;
    bit_cnt_n      = bit_cnt;
    ones_cnt_n     = ones_cnt;
    done_pending_n = done_pending;
    hold_take      = 1'b0;
    byte_done      = 1'b0;
    done           = 1'b0;
    underrun       = 1'b0;
    case (state)
      TX_IDLE: if (hold_valid) begin
        state_n        = TX_SHIFT;
        shifter_n      = hold_data;
        cur_last_n     = hold_last;
        hold_take      = 1'b1;
        bit_cnt_n      = 3'd0;
        ones_cnt_n     = 3'd0;
        done_pending_n = 1'b0;
      end
      TX_SHIFT: if (shift_enable) begin
        shifter_n  = {shifter[BYTE_W-2:0], 1'b0};
        bit_cnt_n  = bit_cnt + 3'd1;
        ones_cnt_n = ones_inc;
        state_n    = stuff ? TX_STUFF : TX_SHIFT;
        if (bit_cnt == 3'd7) begin
          byte_done = 1'b1;
          if (cur_last) begin
            // a trailing stuff bit still belongs to the packet, so done waits for it
            done_pending_n = stuff;
            done           = !stuff;
            state_n        = stuff ? TX_STUFF : TX_IDLE;
          end else if (hold_valid) begin
            shifter_n  = hold_data;
            cur_last_n = hold_last;
            hold_take  = 1'b1;
          end else begin
            underrun = 1'b1;
            state_n  = TX_IDLE;
          end
        end
      end
      TX_STUFF: if (shift_enable) begin
        ones_cnt_n     = 3'd0;
        done           = done_pending;
        done_pending_n = 1'b0;
        state_n        = done_pending ? TX_IDLE : TX_SHIFT;
      end
      default: state_n = TX_IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state        <= TX_IDLE;
      hold_valid   <= 1'b0;
      hold_last    <= 1'b0;
      hold_data    <= '0;
      shifter      <= '0;
      cur_last     <= 1'b0;
      bit_cnt      <= 3'd0;
      ones_cnt     <= 3'd0;
      done_pending <= 1'b0;
    end else begin
      state        <= state_n;
      shifter      <= shifter_n;
      cur_last     <= cur_last_n;
      bit_cnt      <= bit_cnt_n;
      ones_cnt     <= ones_cnt_n;
      done_pending <= done_pending_n;
      if (data_valid && !hold_valid) begin
        hold_valid <= 1'b1;
        hold_last  <= data_last;
        hold_data  <= data_in;
      end else if (hold_take) hold_valid <= 1'b0;
    end
endmodule
